// File: rtl/regbuf_rr_arbiter.sv
// regbuf_rr_arbiter
//   Round-robin arbiter that shares the write port of one external
//   register_buffer among N_REQ producers. The buffer is treated as a
//   1-entry mailbox: it is loaded only while empty and is freed by rd_ack.
//   Build option: define PRIO0_EN to give requester 0 fixed highest
//   priority (a win by requester 0 leaves the round-robin pointer alone).
module regbuf_rr_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  input  logic                     rd_ack,
  output logic [N_REQ-1:0]         gnt,
  output logic                     buf_ld_en,
  output logic [WIDTH-1:0]         buf_d_in,
  output logic                     buf_valid,
  output logic [$clog2(N_REQ)-1:0] buf_owner
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;

  logic              win;
  logic [ID_W-1:0]   win_idx;
  logic              upd_ptr;
  logic [ID_W-1:0]   ptr_inc;
  int unsigned       cand;
  logic [ID_W-1:0]   cand_idx;

  // Pick the winner: first set request scanning rr_ptr upward, modulo N_REQ.
  // The scan index is reduced explicitly so non-power-of-2 N_REQ wraps at N_REQ.
  always_comb begin
    win      = 1'b0;
    win_idx  = '0;
    upd_ptr  = 1'b1;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = ID_W'(cand);
      if (!win && req[cand_idx]) begin
        win     = 1'b1;
        win_idx = cand_idx;
      end
    end
`ifdef PRIO0_EN
    if (req[0]) begin
      win     = 1'b1;
      win_idx = '0;
      upd_ptr = 1'b0;
    end
`endif
    // No grant while the mailbox is occupied or while reset is asserted,
    // so a word offered in the reset cycle is never accepted.
    if (rst || (state_q != EMPTY)) begin
      win = 1'b0;
    end
  end

  // Pointer value following the winner, wrapping after the last requester.
  always_comb begin
    if (win_idx == ID_W'(N_REQ - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = win_idx + 1'b1;
    end
  end

  // One-hot grant and the granted word routed to the buffer input.
  always_comb begin
    gnt      = '0;
    buf_d_in = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win && (win_idx == ID_W'(i))) begin
        gnt[i]   = 1'b1;
        buf_d_in = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign buf_ld_en = |gnt;
  assign buf_valid = (state_q == FULL);
  assign buf_owner = owner_q;

  // Next-state: load on grant while EMPTY, release on rd_ack while FULL.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      EMPTY: begin
        if (win) begin
          state_d = FULL;
          owner_d = win_idx;
          if (upd_ptr) begin
            rr_ptr_d = ptr_inc;
          end
        end
      end
      FULL: begin
        if (rd_ack) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_regbuf_rr_arbiter.sv
// Self-checking bench for regbuf_rr_arbiter (WIDTH=64, N_REQ=4).
// Expected grants come from a small round-robin reference model and are
// queued when a request is driven, then popped when the DUT grants.
`timescale 1ns/1ps
module tb_regbuf_rr_arbiter;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic                   rd_ack;
  logic [N_REQ-1:0]       gnt;
  logic                   buf_ld_en;
  logic [WIDTH-1:0]       buf_d_in;
  logic                   buf_valid;
  logic [ID_W-1:0]        buf_owner;

  always #5 clk = ~clk;

  regbuf_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .rd_ack    (rd_ack),
    .gnt       (gnt),
    .buf_ld_en (buf_ld_en),
    .buf_d_in  (buf_d_in),
    .buf_valid (buf_valid),
    .buf_owner (buf_owner)
  );

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t            sb[$];
  int              passed = 0;
  int              total  = 0;
  logic [ID_W-1:0] m_ptr  = '0;
  logic            m_valid = 1'b0;

  // Reference arbitration: first set request from p upward, modulo N_REQ.
  function automatic int model_pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
    int sel;
    int c;
    logic [ID_W-1:0] ci;
    sel = -1;
`ifdef PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < int'(N_REQ); k++) begin
      c  = (int'(p) + k) % int'(N_REQ);
      ci = ID_W'(c);
      if (sel < 0 && r[ci]) sel = c;
    end
    return sel;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_data();
    for (int i = 0; i < int'(N_REQ); i++)
      req_data[i*WIDTH +: WIDTH] = {$urandom(), $urandom()};
  endtask

  // Queue the grant the model predicts for request vector r (if mailbox empty).
  task automatic expect_grant(input logic [N_REQ-1:0] r);
    int   s;
    exp_t e;
    s = model_pick(r, m_ptr);
    if (!m_valid && s >= 0) begin
      e.id   = ID_W'(s);
      e.data = req_data[s*WIDTH +: WIDTH];
      sb.push_back(e);
      m_valid = 1'b1;
`ifdef PRIO0_EN
      if (s != 0) m_ptr = (s == int'(N_REQ) - 1) ? '0 : ID_W'(s + 1);
`else
      m_ptr = (s == int'(N_REQ) - 1) ? '0 : ID_W'(s + 1);
`endif
    end
  endtask

  // One load/ack transaction with req held throughout. Samples the grant
  // cycle (g, d), the FULL cycle (gf, v, own) and the ack cycle (ga).
  task automatic do_txn(input logic [N_REQ-1:0] r,
                        output logic [N_REQ-1:0] g, output logic [WIDTH-1:0] d,
                        output logic [N_REQ-1:0] gf, output logic v,
                        output logic [ID_W-1:0] own, output logic [N_REQ-1:0] ga);
    req = r;
    expect_grant(r);
    @(negedge clk);
    g = gnt;
    d = buf_d_in;
    step();
    @(negedge clk);
    gf  = gnt;
    v   = buf_valid;
    own = buf_owner;
    step();
    rd_ack = 1'b1;
    @(negedge clk);
    ga = gnt;
    step();
    rd_ack  = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; rd_ack = 1'b0; req_data = '0;
    #1;
    total++; if (buf_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", buf_valid); else passed++;
    total++; if (buf_owner !== '0) $display("FAIL reset_owner: got %0d expected 0", buf_owner); else passed++;
    step();
    new_data();
    req = '1;
    @(negedge clk);
    total++; if (gnt !== '0) $display("FAIL reset_gnt: got %b expected 0000", gnt); else passed++;
    total++; if (buf_ld_en !== 1'b0) $display("FAIL reset_ld_en: got %0b expected 0", buf_ld_en); else passed++;
    total++; if (buf_d_in !== '0) $display("FAIL reset_d_in: got %0h expected 0", buf_d_in); else passed++;
    step();
    rst = 1'b0; req = '0;
    m_ptr = '0; m_valid = 1'b0;
    step();
  endtask

  task automatic test_rr_order();
    logic [N_REQ-1:0] g, gf, ga, eg;
    logic [WIDTH-1:0] d;
    logic v;
    logic [ID_W-1:0] own;
    exp_t e;
    int order[5] = '{0, 1, 2, 3, 0};
    for (int n = 0; n < 5; n++) begin
      new_data();
      do_txn('1, g, d, gf, v, own, ga);
      if (sb.size() == 0) begin
        total++; $display("FAIL rr_sb: no expected entry for txn %0d", n);
      end else begin
        e = sb.pop_front();
        eg = '0; eg[e.id] = 1'b1;
`ifndef PRIO0_EN
        total++; if (int'(e.id) != order[n]) $display("FAIL rr_model_order: got %0d expected %0d", e.id, order[n]); else passed++;
`endif
        total++; if (g !== eg) $display("FAIL rr_gnt: got %b expected %b", g, eg); else passed++;
        total++; if (d !== e.data) $display("FAIL rr_data: got %0h expected %0h", d, e.data); else passed++;
        total++; if (v !== 1'b1 || own !== e.id) $display("FAIL rr_owner: got v=%0b own=%0d expected v=1 own=%0d", v, own, e.id); else passed++;
        total++; if (gf !== '0 || ga !== '0) $display("FAIL rr_full_gnt: got %b/%b expected 0000/0000", gf, ga); else passed++;
      end
    end
    req = '0;
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] g, gf, ga;
    logic [WIDTH-1:0] d;
    logic v;
    logic [ID_W-1:0] own;
    exp_t e;
    new_data();
    req_data[1*WIDTH +: WIDTH] = 64'hA5;
    do_txn(4'b0010, g, d, gf, v, own, ga);
    total++; if (g !== 4'b0010) $display("FAIL single_gnt: got %b expected 0010", g); else passed++;
    total++; if (d !== 64'hA5) $display("FAIL single_data: got %0h expected a5", d); else passed++;
    total++; if (v !== 1'b1 || own !== 2'd1) $display("FAIL single_owner: got v=%0b own=%0d expected v=1 own=1", v, own); else passed++;
    if (sb.size() != 0) e = sb.pop_front();
    req = '0;
  endtask

  // Wrap and skip patterns, then a sequence that separates the PRIO0_EN build.
  task automatic test_patterns();
    logic [N_REQ-1:0] pats[6] = '{4'b0100, 4'b0101, 4'b0100, 4'b0010, 4'b1101, 4'b1100};
    logic [N_REQ-1:0] g, gf, ga, eg;
    logic [WIDTH-1:0] d;
    logic v;
    logic [ID_W-1:0] own;
    exp_t e;
    for (int n = 0; n < 6; n++) begin
      new_data();
      do_txn(pats[n], g, d, gf, v, own, ga);
      if (sb.size() == 0) begin
        total++; $display("FAIL pat_sb: no expected entry for pattern %0d", n);
      end else begin
        e = sb.pop_front();
        eg = '0; eg[e.id] = 1'b1;
        total++; if (g !== eg) $display("FAIL pat_gnt[%0d]: got %b expected %b", n, g, eg); else passed++;
        total++; if (d !== e.data) $display("FAIL pat_data[%0d]: got %0h expected %0h", n, d, e.data); else passed++;
        total++; if (own !== e.id) $display("FAIL pat_owner[%0d]: got %0d expected %0d", n, own, e.id); else passed++;
      end
    end
    req = '0;
  endtask

  task automatic test_ack_empty();
    req = '0; rd_ack = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      @(negedge clk);
      total++; if (buf_valid !== 1'b0 || gnt !== '0) $display("FAIL ack_empty: got v=%0b gnt=%b expected v=0 gnt=0000", buf_valid, gnt); else passed++;
    end
    step();
    rd_ack = 1'b0;
  endtask

  task automatic test_full_block();
    exp_t e;
    logic [N_REQ-1:0] eg;
    new_data();
    req = 4'b0001;
    expect_grant(req);
    @(negedge clk);
    if (sb.size() != 0) e = sb.pop_front();
    total++; if (gnt !== 4'b0001) $display("FAIL fb_first_gnt: got %b expected 0001", gnt); else passed++;
    step();
    req = 4'b1000;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++; if (gnt !== '0 || buf_valid !== 1'b1) $display("FAIL fb_hold: got gnt=%b v=%0b expected 0000 v=1", gnt, buf_valid); else passed++;
      step();
    end
    rd_ack = 1'b1;
    @(negedge clk);
    total++; if (gnt !== '0) $display("FAIL fb_bubble: got %b expected 0000", gnt); else passed++;
    step();
    rd_ack = 1'b0; m_valid = 1'b0;
    expect_grant(req);
    @(negedge clk);
    if (sb.size() == 0) begin
      total++; $display("FAIL fb_sb: no expected entry");
    end else begin
      e = sb.pop_front();
      eg = '0; eg[e.id] = 1'b1;
      total++; if (gnt !== eg || buf_d_in !== e.data) $display("FAIL fb_regrant: got %b/%0h expected %b/%0h", gnt, buf_d_in, eg, e.data); else passed++;
    end
    step();
    req = '0; rd_ack = 1'b1;
    step();
    rd_ack = 1'b0; m_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    exp_t e;
    new_data();
    req = 4'b0100;
    expect_grant(req);
    step();
    req = '1;
    @(negedge clk);
    total++; if (buf_valid !== 1'b1) $display("FAIL rm_full: got %0b expected 1", buf_valid); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (buf_valid !== 1'b0 || buf_owner !== '0 || gnt !== '0) $display("FAIL rm_async: got v=%0b own=%0d gnt=%b expected 0/0/0000", buf_valid, buf_owner, gnt); else passed++;
    sb.delete();
    m_ptr = '0; m_valid = 1'b0;
    step();
    @(negedge clk);
    total++; if (gnt !== '0 || buf_ld_en !== 1'b0) $display("FAIL rm_hold_gnt: got %b ld=%0b expected 0000 ld=0", gnt, buf_ld_en); else passed++;
    step();
    rst = 1'b0;
    expect_grant(req);
    @(negedge clk);
    if (sb.size() == 0) begin
      total++; $display("FAIL rm_sb: no expected entry");
    end else begin
      e = sb.pop_front();
      total++; if (gnt !== 4'b0001 || e.id !== 2'd0) $display("FAIL rm_first_gnt: got %b (model %0d) expected 0001", gnt, e.id); else passed++;
      total++; if (buf_d_in !== e.data) $display("FAIL rm_data: got %0h expected %0h", buf_d_in, e.data); else passed++;
    end
    step();
    req = '0;
    @(negedge clk);
    total++; if (buf_owner !== 2'd0 || buf_valid !== 1'b1) $display("FAIL rm_owner: got v=%0b own=%0d expected v=1 own=0", buf_valid, buf_owner); else passed++;
    step();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0; m_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_order();
    test_single();
    test_patterns();
    test_ack_empty();
    test_full_block();
    test_rst_mid();
    total++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d leftover expected 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
